// File: rtl/uaz8_pkg.sv
// Shared MicroUAZ8 datapath constants: write-data source indices,
// out-of-range select policies and the default word width.
package uaz8_pkg;

   localparam int unsigned DW_SRC_R0    = 0;
   localparam int unsigned DW_SRC_BUS   = 1;
   localparam int unsigned DW_SRC_NUM   = 2;
   localparam int unsigned DW_SRC_IADDR = 3;
   localparam int unsigned DW_SRC_RY    = 4;

   localparam int unsigned ILL_ZERO = 0;
   localparam int unsigned ILL_HOLD = 1;

   localparam int unsigned DW_WIDTH = 8;

endpackage

// File: rtl/uaz8_skid.sv
// Generic 2-entry valid/ready skid buffer: a registered output stage plus one
// overflow entry, so ready_o is registered and never depends on ready_i.
module uaz8_skid #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_full_q, skid_full_d;
   logic             accept;

   always_comb begin
      accept      = valid_i & ~skid_full_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      skid_data_d = skid_data_q;
      skid_full_d = skid_full_q;
      // Output free or draining: refill from the skid first to keep order.
      if (~out_valid_q | ready_i) begin
         if (skid_full_q) begin
            out_data_d  = skid_data_q;
            out_valid_d = 1'b1;
            skid_full_d = 1'b0;
         end else if (accept) begin
            out_data_d  = data_i;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_data_d = data_i;
         skid_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         skid_data_q <= '0;
         skid_full_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         skid_data_q <= skid_data_d;
         skid_full_q <= skid_full_d;
      end
   end

   assign ready_o = ~skid_full_q;
   assign data_o  = out_data_q;
   assign valid_o = out_valid_q;

endmodule

// File: rtl/dw_sel_skid.sv
// Write-data source selector: picks one of NSRC words, applies the illegal
// select fallback, and hands {src_id, word} to a skid buffer.
module dw_sel_skid
   import uaz8_pkg::*;
#(
   parameter int unsigned WIDTH    = DW_WIDTH,
   parameter int unsigned NSRC     = 5,
   parameter int unsigned SEL_W    = 3,
   parameter int unsigned ILL_MODE = ILL_ZERO
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic [SEL_W-1:0]      i_Sel_DW,
   input  logic [NSRC*WIDTH-1:0] i_Src,
   input  logic                  i_Valid,
   output logic                  o_Ready,
   output logic [WIDTH-1:0]      o_DW,
   output logic [SEL_W-1:0]      o_Src_Id,
   output logic                  o_Valid,
   input  logic                  i_Ready,
   output logic                  o_Err,
   input  logic                  i_Err_Clr
);

   localparam int unsigned PW = SEL_W + WIDTH;

   if (NSRC > (1 << SEL_W) || NSRC < 2) begin : g_bad_nsrc
      $error("dw_sel_skid: NSRC must lie in 2..2**SEL_W");
   end

   logic             sel_legal;
   logic [WIDTH-1:0] src_word, sel_word;
   logic             accept;
   logic [WIDTH-1:0] last_good_q, last_good_d;
   logic             err_q, err_d;
   logic [PW-1:0]    out_payload;

   always_comb begin
      src_word  = '0;
      sel_legal = 1'b0;
      // A select is legal exactly when it matches one of the NSRC indices.
      for (int unsigned k = 0; k < NSRC; k++) begin
         if (i_Sel_DW == SEL_W'(k)) begin
            src_word  = i_Src[k*WIDTH +: WIDTH];
            sel_legal = 1'b1;
         end
      end
      if (sel_legal) begin
         sel_word = src_word;
      end else if (ILL_MODE == ILL_HOLD) begin
         sel_word = last_good_q;
      end else begin
         sel_word = '0;
      end
   end

   always_comb begin
      accept      = i_Valid & o_Ready;
      last_good_d = (accept & sel_legal) ? src_word : last_good_q;
      err_d       = (accept & ~sel_legal) | (err_q & ~i_Err_Clr);
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         last_good_q <= '0;
         err_q       <= 1'b0;
      end else begin
         last_good_q <= last_good_d;
         err_q       <= err_d;
      end
   end

   uaz8_skid #(
      .WIDTH(PW)
   ) u_skid (
      .clk_i  (i_Clk),
      .rst_i  (i_Rst),
      .data_i ({i_Sel_DW, sel_word}),
      .valid_i(i_Valid),
      .ready_o(o_Ready),
      .data_o (out_payload),
      .valid_o(o_Valid),
      .ready_i(i_Ready)
   );

   assign o_DW     = out_payload[WIDTH-1:0];
   assign o_Src_Id = out_payload[PW-1:WIDTH];
   assign o_Err    = err_q;

endmodule

// File: tb/tb_dw_sel_skid.sv
// Bench for dw_sel_skid: one instance per fallback policy on shared stimulus,
// checked each cycle against an in-order queue model plus literal expectations.
module tb_dw_sel_skid;
   import uaz8_pkg::*;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 5;
   localparam int unsigned SW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [SW-1:0] sel = '0;
   logic [N*W-1:0] src = '0;
   logic          vld = 1'b0, rdy = 1'b0, clr = 1'b0;

   logic          rdy_o0, v0, err0, rdy_o1, v1, err1;
   logic [W-1:0]  dw0, dw1;
   logic [SW-1:0] id0, id1;

   always #5 clk = ~clk;

   dw_sel_skid #(.WIDTH(W), .NSRC(N), .SEL_W(SW), .ILL_MODE(ILL_ZERO)) u_dut0 (
      .i_Clk(clk), .i_Rst(rst), .i_Sel_DW(sel), .i_Src(src), .i_Valid(vld),
      .o_Ready(rdy_o0), .o_DW(dw0), .o_Src_Id(id0), .o_Valid(v0),
      .i_Ready(rdy), .o_Err(err0), .i_Err_Clr(clr));

   dw_sel_skid #(.WIDTH(W), .NSRC(N), .SEL_W(SW), .ILL_MODE(ILL_HOLD)) u_dut1 (
      .i_Clk(clk), .i_Rst(rst), .i_Sel_DW(sel), .i_Src(src), .i_Valid(vld),
      .o_Ready(rdy_o1), .o_DW(dw1), .o_Src_Id(id1), .o_Valid(v1),
      .i_Ready(rdy), .o_Err(err1), .i_Err_Clr(clr));

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: words in flight kept in accept order; capacity two.
   typedef struct {
      logic [SW-1:0] id;
      logic [W-1:0]  w0;
      logic [W-1:0]  w1;
   } ent_t;

   ent_t          q[$];
   logic          m_err = 1'b0;
   logic [W-1:0]  m_lg  = '0;
   logic [W-1:0]  log0[$];

   function automatic logic [W-1:0] src_of(input logic [N*W-1:0] s, input int unsigned k);
      return s[k*W +: W];
   endfunction

   always @(posedge clk or posedge rst) begin : model
      bit   dlv, acc, legal;
      ent_t e;
      if (rst) begin
         q.delete();
         m_err = 1'b0;
         m_lg  = '0;
      end else begin
         dlv   = (q.size() > 0) && rdy;
         acc   = vld && (q.size() < 2);
         legal = (int'(sel) < int'(N));
         if (dlv) void'(q.pop_front());
         if (acc) begin
            e.id = sel;
            e.w0 = legal ? src_of(src, int'(sel)) : '0;
            e.w1 = legal ? src_of(src, int'(sel)) : m_lg;
            q.push_back(e);
            if (legal) m_lg = src_of(src, int'(sel));
         end
         m_err = (acc && !legal) || (m_err && !clr);
      end
   end

   always @(negedge clk) begin : compare
      chk("valid0", 32'(v0), 32'(q.size() > 0));
      chk("valid1", 32'(v1), 32'(q.size() > 0));
      chk("ready0", 32'(rdy_o0), 32'(q.size() < 2));
      chk("ready1", 32'(rdy_o1), 32'(q.size() < 2));
      chk("err0", 32'(err0), 32'(m_err));
      chk("err1", 32'(err1), 32'(m_err));
      if (q.size() > 0) begin
         chk("dw0", 32'(dw0), 32'(q[0].w0));
         chk("id0", 32'(id0), 32'(q[0].id));
         chk("dw1", 32'(dw1), 32'(q[0].w1));
         chk("id1", 32'(id1), 32'(q[0].id));
      end
      if (!rst && v0 && rdy) log0.push_back(dw0);
   end

   task automatic cyc(input logic v, input logic [SW-1:0] s, input logic r, input logic c);
      vld = v; sel = s; rdy = r; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(input int unsigned k, input logic [W-1:0] val);
      src[k*W +: W] = val;
   endtask

   initial begin : stim
      int unsigned j;
      bit          acc;
      logic [SW-1:0] s;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(v0), 32'd0);
      chk("rst_ready", 32'(rdy_o0), 32'd1);
      chk("rst_dw", 32'(dw0), 32'd0);
      chk("rst_id", 32'(id0), 32'd0);
      chk("rst_err", 32'(err0), 32'd0);
      rst = 1'b0;

      // Single transfers, one per source.
      for (int unsigned k = 0; k < N; k++) set_src(k, W'(8'h10 + k));
      for (int unsigned k = 0; k < N; k++) begin
         cyc(1'b1, SW'(k), 1'b1, 1'b0);
         chk("t1_dw", 32'(dw0), 32'h10 + k);
         chk("t1_id", 32'(id0), k);
         chk("t1_valid", 32'(v0), 32'd1);
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t1_err", 32'(err0), 32'd0);

      // Back-pressure on the immediate source.
      log0.delete();
      j = 1;
      for (int c = 0; c < 3; c++) begin
         set_src(DW_SRC_NUM, W'(j));
         acc = (q.size() < 2);
         cyc(1'b1, SW'(DW_SRC_NUM), 1'b0, 1'b0);
         if (acc) j++;
      end
      chk("t2_ready_low", 32'(rdy_o0), 32'd0);
      chk("t2_accepts", j, 32'd3);
      for (int g = 0; g < 50 && j <= 6; g++) begin
         set_src(DW_SRC_NUM, W'(j));
         acc = (q.size() < 2);
         cyc(1'b1, SW'(DW_SRC_NUM), 1'b1, 1'b0);
         if (acc) j++;
      end
      chk("t2_bound", j, 32'd7);
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t2_count", 32'(log0.size()), 32'd6);
      for (int i = 0; i < 6 && i < log0.size(); i++)
         chk("t2_order", 32'(log0[i]), 32'(i + 1));

      // Illegal selects and sticky error.
      for (int unsigned k = 0; k < N; k++) set_src(k, W'(8'h20 + k));
      cyc(1'b1, 3'd7, 1'b1, 1'b0);
      chk("t3_dw_zero", 32'(dw0), 32'd0);
      chk("t3_id", 32'(id0), 32'd7);
      chk("t3_err_set", 32'(err0), 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t3_err_sticky", 32'(err0), 32'd1);
      cyc(1'b1, 3'd6, 1'b1, 1'b1);
      chk("t3_set_wins", 32'(err0), 32'd1);
      chk("t3_id6", 32'(id0), 32'd6);
      cyc(1'b0, '0, 1'b1, 1'b1);
      chk("t3_err_clr", 32'(err0), 32'd0);

      // Hold-last fallback.
      set_src(DW_SRC_RY, 8'hA5);
      cyc(1'b1, SW'(DW_SRC_RY), 1'b1, 1'b0);
      chk("t4_ry", 32'(dw1), 32'hA5);
      cyc(1'b1, 3'd5, 1'b1, 1'b0);
      chk("t4_hold", 32'(dw1), 32'hA5);
      chk("t4_zero", 32'(dw0), 32'h00);
      chk("t4_id5", 32'(id1), 32'd5);
      set_src(DW_SRC_R0, 8'h3C);
      cyc(1'b1, SW'(DW_SRC_R0), 1'b1, 1'b0);
      chk("t4_r0_1", 32'(dw1), 32'h3C);
      chk("t4_r0_0", 32'(dw0), 32'h3C);
      cyc(1'b0, '0, 1'b1, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b0);

      // Full-rate streaming with random legal selects.
      log0.delete();
      for (int c = 0; c < 16; c++) begin
         for (int unsigned k = 0; k < N; k++) set_src(k, W'($urandom));
         cyc(1'b1, SW'($urandom_range(0, N - 1)), 1'b1, 1'b0);
         chk("t5_valid", 32'(v0), 32'd1);
      end
      repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t5_count", 32'(log0.size()), 32'd16);

      // Asynchronous reset with both stages full.
      cyc(1'b1, 3'd1, 1'b0, 1'b0);
      cyc(1'b1, 3'd3, 1'b0, 1'b0);
      chk("t6_full", 32'(rdy_o0), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid", 32'(v0), 32'd0);
      chk("t6_ready", 32'(rdy_o0), 32'd1);
      chk("t6_dw", 32'(dw0), 32'd0);
      chk("t6_valid1", 32'(v1), 32'd0);
      vld = 1'b0; rdy = 1'b1;
      @(posedge clk);
      #3;
      rst = 1'b0;
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t6_no_stale", 32'(v0), 32'd0);

      // Random traffic including illegal selects, stalls and clears.
      for (int c = 0; c < 400; c++) begin
         for (int unsigned k = 0; k < N; k++) set_src(k, W'($urandom));
         s = SW'($urandom_range(0, 7));
         cyc($urandom_range(0, 3) != 0, s, $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
      end
      repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dw_sel_skid.md
Name: dw_sel_skid

Overview:
- Next-generation write-data source selector for the MicroUAZ8 datapath; sits between the operand sources (R0, immediate, data bus, instruction address bus, Ry and any later additions) and the register-file/memory write port.
- Generalised in width and source count.
- Registers the selected word and moves it over a valid/ready handshake through a 2-entry skid buffer, so a stalled write port never drops data.
- Flags out-of-range selects with a sticky error, and supports a zero or hold-last fallback policy.

Parameters:
- WIDTH, 8, data word width in bits.
- NSRC, 5, number of selectable sources (2..2**SEL_W).
- SEL_W, 3, select field width.
- ILL_MODE, 0, out-of-range select policy: 0 = emit zero, 1 = emit last legally selected word.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_Sel_DW  in  SEL_W  source index.
- i_Src  in  NSRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH]. Source 0 = R0, 1 = data bus, 2 = immediate, 3 = instruction address bus, 4 = Ry.
- i_Valid  in  1  upstream offers a select/word this cycle.
- o_Ready  out  1  block can accept; high when the skid entry is empty.
- o_DW  out  WIDTH  registered selected word.
- o_Src_Id  out  SEL_W  index that produced o_DW.
- o_Valid  out  1  o_DW/o_Src_Id hold a valid word.
- i_Ready  in  1  write port consumes the word this cycle.
- o_Err  out  1  sticky out-of-range select flag.
- i_Err_Clr  in  1  clears o_Err.

Behaviour:
- Reset values (asynchronous, while i_Rst = 1):
  - o_Valid = 0, o_DW = 0, o_Src_Id = 0, o_Err = 0.
  - Skid entry empty, so o_Ready = 1.
  - Last-good register = 0.
- Accept and deliver:
  - Accept occurs when i_Valid & o_Ready at a rising edge.
  - Deliver occurs when o_Valid & i_Ready.
- Selection:
  - If i_Sel_DW < NSRC, the word is source[i_Sel_DW] and the last-good register is updated with it on accept.
  - Otherwise (illegal), the word is 0 (ILL_MODE = 0) or last-good (ILL_MODE = 1). Last-good is not updated.
  - An illegal select is still accepted and delivered, with o_Src_Id = the raw illegal index.
- Latency: 1 cycle; an accepted word appears on o_DW the next cycle when the output stage is empty or draining.
- Output stage update (each edge):
  - If !o_Valid | i_Ready, the output loads the skid entry if the skid is full, else the accepted input if any, else o_Valid goes to 0.
  - Otherwise the output holds; o_DW/o_Src_Id stay stable while o_Valid & !i_Ready.
- Skid entry:
  - Loads the accepted word when the output stage is full and not draining.
  - Empties when its content moves to the output.
  - o_Ready = !skid_full, registered, with no combinational path from i_Ready.
- Ordering: words are delivered strictly in accept order. No loss, no duplication; throughput is 1 word/cycle when i_Ready is held high.
- Simultaneous accept and deliver with the skid empty: the output takes the new word, o_Valid stays 1, and the skid remains empty.
- Both stages full with !i_Ready: o_Ready = 0, and i_Valid is ignored until a deliver.
- o_Err:
  - Set on accept of an illegal select.
  - i_Err_Clr clears it.
  - When set and clear occur in the same cycle, set wins.
  - Offered-but-not-accepted illegal selects do not set it.
- Reset mid-transfer discards both stages immediately; no word is delivered after reset release until a new accept.
- Widths: no arithmetic. i_Sel_DW is compared unsigned against NSRC. Elaboration fails if NSRC > 2**SEL_W or NSRC < 2.

Decomposition:
- Shared package uaz8_pkg holds:
  - Constants DW_SRC_R0 = 0, DW_SRC_BUS = 1, DW_SRC_NUM = 2, DW_SRC_IADDR = 3, DW_SRC_RY = 4.
  - ILL_ZERO = 0, ILL_HOLD = 1.
  - The default WIDTH = 8.
- One sub-module, uaz8_skid: a generic 2-entry valid/ready skid buffer with parameter WIDTH, carrying {src_id, word}.
- The top level holds the select/fallback logic, the last-good register and o_Err.

Test Plan:
- Reset then single transfers: Sel = 0..4 with source k = 8'h10+k, i_Ready = 1 -> o_DW = 10,11,12,13,14 one cycle after each accept; o_Src_Id matches; o_Err = 0.
- Back-pressure: stream Sel = 2 with immediate values 01..06 and i_Ready = 0 for 3 cycles -> o_Ready falls after 2 accepts; after i_Ready = 1, words arrive in order 01..06 with no gaps or loss.
- Illegal, ILL_MODE = 0: Sel = 7 accepted -> o_DW = 00, o_Src_Id = 7, o_Err = 1 stays set. Assert i_Err_Clr together with another Sel = 6 accept -> o_Err stays 1; a later lone clear -> 0.
- Illegal, ILL_MODE = 1: Sel = 4 with Ry = 8'hA5, then Sel = 5 -> second word = A5; a following Sel = 0 with R0 = 3C -> 3C.
- Simultaneous accept/deliver at full rate for 16 cycles with random legal selects -> one output per cycle, exact match to the scoreboard.
- Async reset asserted mid-edge while both stages are full -> o_Valid = 0, o_Ready = 1, o_DW = 0 immediately; no stale word delivered after release.
